// File: rtl/awg_timing_pkg.sv
// Shared timing constants and helpers for the AWG control path.
// Provides the default clock rate and the prescaler width rule.
package awg_timing_pkg;

    localparam int CLK_FREQ_HZ_DEFAULT = 50_000_000;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Enabled modulo-N counter with a registered terminal-count pulse.
// The pulse is high the cycle after the count wraps from N-1 to 0.
module mod_n_counter
    import awg_timing_pkg::*;
#(
    parameter int N = CLK_FREQ_HZ_DEFAULT,
    localparam int W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_count;
    logic         r_tc;
    logic         w_last;

    assign w_last = (r_count == LAST);

    // Count enabled cycles; clear and reset win over a coincident wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (en) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
            r_tc    <= w_last;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

endmodule

// File: rtl/t1s_gen.sv
// One-second timebase: strobe, 0.5 Hz square wave, seconds counter.
// The prescaler wrap edge also updates the level and seconds registers.
module t1s_gen
    import awg_timing_pkg::*;
#(
    parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int SEC_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic             s,
    output logic             s_level,
    output logic [SEC_W-1:0] sec_cnt
);

    localparam int CW = cnt_width(CLK_FREQ_HZ);
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

    logic [CW-1:0]    w_count;
    logic             w_tc;
    logic             w_wrap;
    logic             r_level;
    logic [SEC_W-1:0] r_sec;

    mod_n_counter #(
        .N(CLK_FREQ_HZ)
    ) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (clr),
        .count(w_count),
        .tc   (w_tc)
    );

    assign w_wrap = en && !clr && (w_count == LAST);

    // Toggle the level and bump seconds on the same edge the prescaler wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_sec   <= '0;
        end else if (clr) begin
            r_sec   <= '0;
        end else if (w_wrap) begin
            r_level <= ~r_level;
            r_sec   <= r_sec + 1'b1;
        end
    end

    assign s       = w_tc;
    assign s_level = r_level;
    assign sec_cnt = r_sec;

endmodule

// File: tb/tb_t1s_gen.sv
// Self-checking bench for t1s_gen: three parameterisations driven in
// parallel, directed scenarios plus random stimulus against a model.
module tb_t1s_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    logic        s_a, l_a;
    logic [15:0] sec_a;
    logic        s_b, l_b;
    logic [1:0]  sec_b;
    logic        s_c, l_c;
    logic [7:0]  sec_c;

    t1s_gen #(.CLK_FREQ_HZ(10), .SEC_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .s(s_a), .s_level(l_a), .sec_cnt(sec_a)
    );
    t1s_gen #(.CLK_FREQ_HZ(3), .SEC_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .s(s_b), .s_level(l_b), .sec_cnt(sec_b)
    );
    t1s_gen #(.CLK_FREQ_HZ(1000), .SEC_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .s(s_c), .s_level(l_c), .sec_cnt(sec_c)
    );

    logic        s_o   [3];
    logic        lvl_o [3];
    logic [15:0] sec_o [3];

    assign s_o[0] = s_a;
    assign s_o[1] = s_b;
    assign s_o[2] = s_c;
    assign lvl_o[0] = l_a;
    assign lvl_o[1] = l_b;
    assign lvl_o[2] = l_c;
    assign sec_o[0] = sec_a;
    assign sec_o[1] = {14'b0, sec_b};
    assign sec_o[2] = {8'b0, sec_c};

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: enabled time since reset/clear, and strobes since reset.
    longint NN [3] = '{10, 3, 1000};
    longint WW [3] = '{16, 2, 8};
    longint el [3] = '{0, 0, 0};
    longint st [3] = '{0, 0, 0};
    bit     sx [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                el[i] <= 0;
                st[i] <= 0;
                sx[i] <= 1'b0;
            end else if (clr) begin
                el[i] <= 0;
                sx[i] <= 1'b0;
            end else if (en) begin
                el[i] <= el[i] + 1;
                if ((el[i] + 1) % NN[i] == 0) begin
                    st[i] <= st[i] + 1;
                    sx[i] <= 1'b1;
                end else begin
                    sx[i] <= 1'b0;
                end
            end else begin
                sx[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("m%0d_s", i), 64'(s_o[i]), 64'(sx[i]));
                chk($sformatf("m%0d_lvl", i), 64'(lvl_o[i]),
                    64'(st[i] % 2));
                chk($sformatf("m%0d_sec", i), 64'(sec_o[i]),
                    64'((el[i] / NN[i]) % (64'd1 << WW[i])));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int first;
        int second;

        rst_n = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        step(2);
        chk_on = 1'b1;
        chk("rst_s", 64'(s_a), 0);
        chk("rst_lvl", 64'(l_a), 0);
        chk("rst_sec", 64'(sec_a), 0);

        rst_n = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            chk($sformatf("per_s_%0d", k), 64'(s_a), 64'(k % 10 == 0));
            if (k % 10 == 0) begin
                chk($sformatf("per_sec_%0d", k), 64'(sec_a), 64'(k / 10));
                chk($sformatf("per_lvl_%0d", k), 64'(l_a),
                    64'((k / 10) % 2));
            end
        end

        step(4);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1);
            chk("gate_off_s", 64'(s_a), 0);
        end
        en = 1'b1;
        step(5);
        chk("gate_early_s", 64'(s_a), 0);
        step(1);
        chk("gate_s", 64'(s_a), 1);
        chk("gate_sec", 64'(sec_a), 4);
        chk("gate_lvl", 64'(l_a), 0);

        step(9);
        chk("clr_pre_s", 64'(s_a), 0);
        clr = 1'b1;
        step(1);
        chk("clr_s", 64'(s_a), 0);
        chk("clr_sec", 64'(sec_a), 0);
        chk("clr_lvl", 64'(l_a), 0);
        clr = 1'b0;
        step(9);
        chk("clr_early_s", 64'(s_a), 0);
        step(1);
        chk("clr_next_s", 64'(s_a), 1);
        chk("clr_next_sec", 64'(sec_a), 1);
        chk("clr_next_lvl", 64'(l_a), 1);

        step(7);
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_s", 64'(s_a), 0);
        chk("mid_rst_lvl", 64'(l_a), 0);
        chk("mid_rst_sec", 64'(sec_a), 0);
        rst_n = 1'b1;
        step(9);
        chk("mid_early_s", 64'(s_a), 0);
        step(1);
        chk("mid_next_s", 64'(s_a), 1);
        chk("mid_next_sec", 64'(sec_a), 1);
        chk("mid_next_lvl", 64'(l_a), 1);

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(15);
        chk("wrap_s", 64'(s_b), 1);
        chk("wrap_sec", 64'(sec_b), 1);
        chk("wrap_lvl", 64'(l_b), 1);

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        first = -1;
        second = -1;
        for (int k = 1; k <= 2500 && second < 0; k++) begin
            step(1);
            if (s_c) begin
                if (first < 0) first = k;
                else second = k;
            end
        end
        chk("big_first", 64'(first), 1000);
        chk("big_period", 64'(second - first), 1000);

        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            en = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 999) < 4);
            step(1);
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/t1s_gen.md
Name: t1s_gen

Overview:
- Free-running one-second timebase for the AWG control path.
- Divides the system clock by CLK_FREQ_HZ and emits a single-cycle strobe `s` once per second.
- Also provides a 0.5 Hz square wave and a wrapping seconds counter.
- Consumed by the command/state selector, e.g. to step frequency once per second.

Parameters:
- CLK_FREQ_HZ, 50_000_000, input clock frequency and divide ratio (one strobe every CLK_FREQ_HZ enabled cycles); legal range >= 2.
- SEC_W, 16, width of the seconds counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  count enable; prescaler holds while low.
- clr  in  1  synchronous clear of the prescaler and seconds counter.
- s  out  1  one-second strobe, high for exactly one clk cycle.
- s_level  out  1  toggles on every strobe (0.5 Hz square wave).
- sec_cnt  out  SEC_W  number of strobes since reset/clear; wraps modulo 2^SEC_W.

Behaviour:
- One clock, one reset. Reset is synchronous and active-low (`rst_n` sampled on `posedge clk`). All outputs are registered.
- Reset values:
  - prescaler count = 0
  - s = 0
  - s_level = 0
  - sec_cnt = 0
- Prescaler `cnt` has width clog2(CLK_FREQ_HZ) and counts 0..CLK_FREQ_HZ-1. It increments only on edges where en=1 and no reset/clr is active.
- Strobe generation, on an edge with en=1 and cnt==CLK_FREQ_HZ-1:
  - cnt wraps to 0
  - s is registered high for the following cycle
  - s_level inverts
  - sec_cnt increments
- s is 0 on every other cycle, including every cycle where en=0.
- Timing: with en held at 1 from reset release, s is first high after the CLK_FREQ_HZ-th enabled rising edge. Thereafter s is high exactly once every CLK_FREQ_HZ cycles. No cumulative drift: the period is exact.
- en=0 freezes cnt, s_level and sec_cnt and forces s=0 next cycle. On resume, counting continues from the frozen cnt, so elapsed enabled time is preserved.
- clr=1 (synchronous):
  - cnt=0, s=0, sec_cnt=0
  - s_level is NOT cleared
  - clr has priority over en and over a coincident terminal count, so no strobe is issued that cycle.
- Reset has priority over clr and en.
- Reset mid-count discards the partial second; the next strobe comes a full CLK_FREQ_HZ enabled cycles after release.
- sec_cnt wraps from 2^SEC_W-1 to 0 with no flag.
- Arithmetic is unsigned. The terminal-count compare uses the constant CLK_FREQ_HZ-1 at full counter width, with no truncation warnings.

Decomposition:
- Shared package `awg_timing_pkg`:
  - CLK_FREQ_HZ_DEFAULT (50_000_000)
  - a clog2-derived counter-width constant/function
- Sub-module `mod_n_counter`:
  - parameter N
  - inputs clk, rst_n, en, clr
  - outputs count and terminal-count pulse `tc` (registered)
- t1s_gen instantiates mod_n_counter with N=CLK_FREQ_HZ and adds the s_level toggle and the sec_cnt register around it.

Test Plan:
- Basic period (CLK_FREQ_HZ=10, en=1 after reset):
  - s pulses one cycle wide on the 10th, 20th and 30th edge after reset release.
  - sec_cnt reads 1, 2, 3; s_level reads 1, 0, 1.
- Enable gating (CLK_FREQ_HZ=10): count 4 cycles, drop en for 7 cycles, re-enable.
  - No s while en=0.
  - Next s arrives 6 enabled cycles after resume.
- Clear:
  - clr asserted coincident with terminal count → no s pulse, sec_cnt=0, s_level unchanged.
  - Next s arrives 10 cycles after clr deasserts.
- Reset mid-count: rst_n low at cnt=7 for 1 cycle → all outputs 0; next s 10 cycles after release.
- Wrap (SEC_W=2, CLK_FREQ_HZ=3): after 5 strobes sec_cnt=1 (wrapped 3→0→1); s_level=1.
- Default-parameter sanity (CLK_FREQ_HZ=50_000_000): count cycles between the first two s pulses → exactly 50_000_000.
